fxp24s_shift_arbiter: RTL and testbench
=======================================

# fxp24s_shift_arbiter

Shares one fxp24s variable-shift datapath between `N_REQ` independent requesters. Round-robin arbitration over valid/ready request ports, one registered output stage tagged with the winning requester's index. Sits between the normalisation/scaling producers and the downstream accumulator. Removes the need for a shifter instance per producer.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: width of requester index; must equal clog2(`N_REQ`).
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: request valid, one bit per requester.
- `req_ready` out `N_REQ`: request accepted this cycle, one-hot or zero.
- `req_data` in `N_REQ*24`: fxp24s operand; requester i at bits [24i+23:24i].
- `req_shift` in `N_REQ*24`: unsigned shift amount; requester i at [24i+23:24i].
- `req_sign` in `N_REQ`: shift direction; 0 = left shift, 1 = right shift.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_data` out 24: shifted fxp24s result.
- `out_id` out `ID_W`: index of the requester that produced `out_data`.

## Operation
- **Shift function** (combinational, on the granted operand d, amount s, direction r):
  - If s[23:5] != 0, the result is 24'h000000.
  - Otherwise, when r=0: t = (d << s[4:0]) truncated to 24 bits, with zero fill.
  - Otherwise, when r=1: t = d arithmetic-shifted right by s[4:0], filling with d[23].
  - Result = {d[23], t[22:0]}. The sign bit is always the input sign; there is no overflow detection on left shift.
- **Accept condition:** `can_accept = !out_valid | out_ready`.
- **Arbiter:**
  - Round-robin pointer `rr_ptr` (`ID_W` bits).
  - Grant goes to the first i with `req_valid[i]=1`, searching `rr_ptr`, `rr_ptr+1`, … mod `N_REQ`.
  - `req_ready[i] = can_accept & grant[i]`. At most one bit of `req_ready` is high.
  - Transfer from requester i occurs when `req_valid[i] & req_ready[i]`.
  - On a transfer, `rr_ptr <= (i+1) mod N_REQ`. Otherwise `rr_ptr` holds.
  - Grant is combinational from the current `req_valid`. It may change between cycles if no transfer occurred; this is legal.
- **Requester rules:**
  - Once `req_valid[i]` is asserted, it stays high with stable `req_data`/`req_shift`/`req_sign` until the transfer.
  - The arbiter does not check this.
- **Output register:**
  - On a transfer: `out_data <=` shift result, `out_id <=` i, `out_valid <= 1`.
  - Else if `out_ready`: `out_valid <= 0`, and `out_data`/`out_id` hold.
  - While `out_valid & !out_ready`, all outputs are stable and no `req_ready` is asserted.
- **Simultaneous drain and accept:** when `out_valid & out_ready` and a new transfer occur in the same cycle, the register reloads and `out_valid` stays 1. There is no bubble.
- **No requests:** `req_ready` = 0 and `rr_ptr` holds.
- **Reset:**
  - `out_valid=0`, `out_data=24'h0`, `out_id=0`, `rr_ptr=0`, `req_ready=0`.
  - Reset mid-operation discards any held result without handshake.
  - The first cycle after `rst` deasserts may accept a request.

## Timing
- Latency: a transfer at rising edge k makes the result visible on `out_data`/`out_valid` after edge k; downstream may consume it at edge k+1.
- Throughput: one result per cycle while `out_ready=1`.
- `req_ready` depends combinationally on `req_valid`, `out_valid`, `out_ready` and `rr_ptr`.
- No combinational path from `req_data`/`req_shift` to any output.
- `out_*` are driven directly from flops.
- Fairness: with all requesters continuously valid and `out_ready=1`, each requester is granted exactly once every `N_REQ` cycles.

## Test plan
- **Reset and basic shifts:** after reset, `out_valid=0` and `req_ready=0`.
  - Req0 `data=24'h000100`, `shift=4`, `sign=0` -> next cycle `out_data=24'h001000`, `out_id=0`.
  - Req0 `24'h800100`, shift 4, `sign=1` -> `24'hF80010`.
  - Req0 `24'h400001`, shift 1, `sign=0` -> `24'h000002`.
  - Req0 any data, `shift=24'h000020` -> `24'h000000`.
- **Fairness:** all four requesters hold valid, `out_ready=1` for 8 cycles -> `out_id` sequence 0,1,2,3,0,1,2,3; each `req_ready` pulses once per 4 cycles.
- **Backpressure:** with `out_valid=1`, hold `out_ready=0` for 5 cycles while req2 is valid.
  - `req_ready` stays 0 and `out_data`/`out_id` stay stable.
  - Raise `out_ready` -> req2 accepted the same cycle, and `out_valid` stays 1 with `out_id=2` next cycle.
- **Pointer advance and hold:** `rr_ptr=0`, only req3 valid -> req3 granted, next pointer 0 (wraps).
  - Then req1 and req3 valid -> req1 granted.
  - With no requests for 3 cycles, the pointer is unchanged.
- **Reset mid-stream:** assert `rst` while `out_valid=1` and `out_ready=0` -> next cycle `out_valid=0`, `out_data=0`, `out_id=0`.
  - Following arbitration starts from req0.

Source files
------------

// File: rtl/fxp24s_shift_arbiter.sv
// Purpose: round-robin arbiter sharing one fxp24s variable shifter between N_REQ requesters.
// Latency: 1 cycle, transfer at edge k gives a registered result after edge k.
// Backpressure: no request is granted while out_valid & !out_ready; a drain and a reload can happen in the same cycle.
//
// Ports:
//   clk, rst              - single clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake, req_ready one-hot or zero
//   req_data/req_shift    - packed per-requester operand and shift amount, 24 bits each
//   req_sign              - per-requester direction, 0 = left, 1 = arithmetic right
//   out_valid/out_ready   - result handshake
//   out_data/out_id       - registered shift result and index of the requester that produced it
module fxp24s_shift_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*24-1:0]   req_data,
    input  logic [N_REQ*24-1:0]   req_shift,
    input  logic [N_REQ-1:0]      req_sign,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [23:0]           out_data,
    output logic [ID_W-1:0]       out_id
);

    // One extra bit so index sums can be compared against N_REQ before wrapping.
    localparam int SW = ID_W + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    nxt_ptr;
    logic               found;
    logic               can_accept;
    logic               xfer;
    logic [2*N_REQ-1:0] rot2;
    logic [SW-1:0]      sum;
    logic [SW-1:0]      nsum;

    logic [23:0]        sel_d;
    logic [23:0]        sel_s;
    logic               sel_r;
    logic [23:0]        t;
    logic [23:0]        shift_res;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr;
    // the first set bit j then names requester (rr_ptr + j) mod N_REQ.
    always_comb begin
        rot2   = {req_valid, req_valid} >> rr_ptr;
        found  = 1'b0;
        win_id = '0;
        sum    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && rot2[j]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + SW'(j);
                if (sum >= SW'(N_REQ)) begin
                    sum = sum - SW'(N_REQ);
                end
                win_id = sum[ID_W-1:0];
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at N_REQ.
    always_comb begin
        nsum = {1'b0, win_id} + SW'(1);
        if (nsum >= SW'(N_REQ)) begin
            nsum = '0;
        end
        nxt_ptr = nsum[ID_W-1:0];
    end

    assign can_accept = !out_valid || out_ready;
    // Held low in reset so no handshake is seen while the output stage is cleared.
    assign xfer       = found && can_accept && !rst;
    assign req_ready  = xfer ? (N_REQ'(1) << win_id) : '0;

    // Operand mux for the winning requester.
    always_comb begin
        sel_d = '0;
        sel_s = '0;
        sel_r = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_d = req_data[24*i +: 24];
                sel_s = req_shift[24*i +: 24];
                sel_r = req_sign[i];
            end
        end
    end

    // Shift amounts of 32 or more flush to zero, including the sign bit.
    // Otherwise the input sign bit is always kept, even when a left shift
    // would have pushed a different value into bit 23.
    always_comb begin
        t         = '0;
        shift_res = '0;
        if (|sel_s[23:5]) begin
            shift_res = '0;
        end else begin
            if (sel_r) begin
                t = $signed(sel_d) >>> sel_s[4:0];
            end else begin
                t = sel_d << sel_s[4:0];
            end
            shift_res = {sel_d[23], t[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= shift_res;
                out_id    <= win_id;
                rr_ptr    <= nxt_ptr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fxp24s_shift_arbiter.sv
module tb_fxp24s_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_data;
    logic [95:0] req_shift;
    logic [3:0]  req_sign;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [1:0]  out_id;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [23:0] data;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    fxp24s_shift_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_sign  (req_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    // Reference shift built one bit position at a time.
    function automatic logic [23:0] ref_shift(logic [23:0] d, logic [23:0] s, logic r);
        logic [23:0] t;
        t = d;
        if (s[23:5] != 19'd0) return 24'h000000;
        for (int k = 0; k < 32; k++) begin
            if (k < int'(s[4:0])) begin
                if (r) t = {t[23], t[23:1]};
                else   t = {t[22:0], 1'b0};
            end
        end
        return {d[23], t[22:0]};
    endfunction

    // Scoreboard: handshakes are judged at the falling edge, where they are
    // stable and will take effect at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got id=%0d data=%06h, required no output", out_id, out_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_id, out_data} !== e) begin
                        failures++;
                        $display("FAIL sb_result: got id=%0d data=%06h, required id=%0d data=%06h",
                                 out_id, out_data, e.id, e.data);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = 2'(i);
                    e.data = ref_shift(req_data[24*i +: 24], req_shift[24*i +: 24], req_sign[i]);
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(int i, logic [23:0] d, logic [23:0] s, logic r);
        req_data[24*i +: 24]  = d;
        req_shift[24*i +: 24] = s;
        req_sign[i]           = r;
        req_valid[i]          = 1'b1;
    endtask

    // Raises one request, waits (bounded) for its grant, drops it after the transfer edge.
    task automatic send(int i, logic [23:0] d, logic [23:0] s, logic r);
        int n;
        set_req(i, d, s, r);
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready[i]) begin
            failures++;
            $display("FAIL send_timeout: req%0d got no ready, required ready within 50 cycles", i);
        end
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        set_req(0, 24'h000100, 24'd4, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
        reset_dut();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || out_id !== 2'd0 || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b data=%06h id=%0d ready=%b, required 0/000000/0/0000",
                     out_valid, out_data, out_id, req_ready);
        end
    endtask

    task automatic test_basic_shifts();
        logic [23:0] vd[5] = '{24'h000100, 24'h800100, 24'h400001, 24'h7ABCDE, 24'h800000};
        logic [23:0] vs[5] = '{24'd4, 24'd4, 24'd1, 24'h000020, 24'h000100};
        logic        vr[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [23:0] ve[5] = '{24'h001000, 24'hF80010, 24'h000002, 24'h000000, 24'h000000};
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            send(0, vd[v], vs[v], vr[v]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== ve[v] || out_id !== 2'd0) begin
                failures++;
                $display("FAIL basic_shift%0d: got valid=%b data=%06h id=%0d, required 1/%06h/0",
                         v, out_valid, out_data, out_id, ve[v]);
            end
        end
    endtask

    task automatic test_fairness();
        int pulses[4] = '{0, 0, 0, 0};
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 24'h000011 * 24'(i + 1), 24'(i), 1'b0);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (req_ready[i]) pulses[i]++;
            checks++;
            if (req_ready !== (4'b0001 << (c % 4))) begin
                failures++;
                $display("FAIL fair_grant%0d: got %b, required %b", c, req_ready, 4'b0001 << (c % 4));
            end
            if (c > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'((c - 1) % 4)) begin
                    failures++;
                    $display("FAIL fair_id%0d: got valid=%b id=%0d, required 1/%0d", c, out_valid, out_id, (c - 1) % 4);
                end
            end
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (out_id !== 2'd3) begin
            failures++;
            $display("FAIL fair_last_id: got %0d, required 3", out_id);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pulses[i] != 2) begin
                failures++;
                $display("FAIL fair_pulses%0d: got %0d, required 2", i, pulses[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        send(0, 24'h123456, 24'd2, 1'b0);
        set_req(2, 24'hFFFF00, 24'd8, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== 24'h48D158 || out_id !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold%0d: got ready=%b valid=%b data=%06h id=%0d, required 0000/1/48d158/0",
                         c, req_ready, out_valid, out_data, out_id);
            end
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_release_ready: got %b, required 0100", req_ready);
        end
        step();
        req_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL bp_reload: got valid=%b id=%0d data=%06h, required 1/2/ffffff", out_valid, out_id, out_data);
        end
    endtask

    task automatic test_pointer();
        reset_dut();
        out_ready = 1'b1;
        set_req(3, 24'h000003, 24'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL ptr_only3: got %b, required 1000", req_ready);
        end
        step();
        set_req(1, 24'h000001, 24'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL ptr_wrap: got %b, required 0010", req_ready);
        end
        step();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0) begin
                failures++;
                $display("FAIL ptr_idle%0d: got %b, required 0000", c, req_ready);
            end
        end
        step();
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL ptr_held: got %b, required 1000", req_ready);
        end
        step();
        req_valid = '0;
    endtask

    task automatic test_reset_midstream();
        step();
        out_ready = 1'b0;
        send(1, 24'h0000F0, 24'd3, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 24'h000100 + 24'(i), 24'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || out_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_out: got valid=%b data=%06h id=%0d, required 0/000000/0", out_valid, out_data, out_id);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_reset_ptr: got %b, required 0001", req_ready);
        end
        step();
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shift = '0;
        req_sign  = '0;
        out_ready = 1'b1;

        test_reset();
        test_basic_shifts();
        test_fairness();
        test_backpressure();
        test_pointer();
        test_reset_midstream();

        step();
        step();
        step();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
